// File: rtl/dff_if.sv
// =============================================================================
// Module      : dff_if
// Description : Data/enable/output bundle for the dff storage cell.
//               The valid member exists only when DFF_VALID_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface dff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic             re;
  logic             we;
  logic [WIDTH-1:0] q;
`ifdef DFF_VALID_EN
  logic             valid;

  modport master (output d, re, we, input q, valid);
  modport slave  (input d, re, we, output q, valid);
`else
  modport master (output d, re, we, input q);
  modport slave  (input d, re, we, output q);
`endif
endinterface : dff_if

`default_nettype wire

// File: rtl/dff.sv
// =============================================================================
// Module      : dff
// Description : Single-entry capture/present storage cell with active-low
//               read-in (re) and write-out (we) enables. Optional feature
//               macro DFF_VALID_EN adds a sticky store-loaded flag.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dff #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic clk,
  input  wire logic rst,
  dff_if.slave      bus
);

  logic [WIDTH-1:0] r_store;
  logic [WIDTH-1:0] r_q;

  // q always samples the pre-edge store, so re=0/we=0 together shift rather
  // than write through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store <= RESET_VAL;
      r_q     <= RESET_VAL;
    end else begin
      if (!bus.re) begin
        r_store <= bus.d;
      end
      if (!bus.we) begin
        r_q <= r_store;
      end
    end
  end

  assign bus.q = r_q;

`ifdef DFF_VALID_EN
  logic r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (!bus.re) begin
      r_valid <= 1'b1;
    end
  end

  assign bus.valid = r_valid;
`endif

endmodule : dff

`default_nettype wire

// File: tb/tb_dff.sv
// =============================================================================
// Module      : tb_dff
// Description : Self-checking bench for dff (WIDTH=8): directed scenarios plus
//               randomized enables/data against a cycle-level reference model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dff;
  localparam int             C_WIDTH = 8;
  localparam logic [7:0]     C_RST   = 8'h00;

  logic clk;
  logic rst;

  dff_if #(.WIDTH(C_WIDTH)) bus ();

  dff #(.WIDTH(C_WIDTH), .RESET_VAL(C_RST)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: the value captured, the value presented, and whether any
  // capture has happened since reset.
  logic [7:0] m_store;
  logic [7:0] m_q;
  logic       m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic tick(input logic t_rst, input logic t_re, input logic t_we, input logic [7:0] t_d);
    logic [7:0] old_store;
    @(negedge clk);
    rst    = t_rst;
    bus.re = t_re;
    bus.we = t_we;
    bus.d  = t_d;
    @(posedge clk);
    old_store = m_store;
    if (t_rst) begin
      m_store = C_RST;
      m_q     = C_RST;
      m_valid = 1'b0;
    end else begin
      if (t_we == 1'b0) m_q = old_store;
      if (t_re == 1'b0) begin
        m_store = t_d;
        m_valid = 1'b1;
      end
    end
    #1;
    chk("model_q", {24'd0, bus.q}, {24'd0, m_q});
`ifdef DFF_VALID_EN
    chk("model_valid", {31'd0, bus.valid}, {31'd0, m_valid});
`endif
  endtask

  initial begin
    rst     = 1'b1;
    bus.re  = 1'b1;
    bus.we  = 1'b1;
    bus.d   = 8'h00;
    m_store = 8'h5A;
    m_q     = 8'h5A;
    m_valid = 1'b0;

    // Reset, then prove the store was cleared by presenting it.
    tick(1'b1, 1'b1, 1'b1, 8'h00);
    tick(1'b1, 1'b1, 1'b1, 8'h00);
    chk("reset_q", {24'd0, bus.q}, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    chk("reset_store", {24'd0, bus.q}, 32'h0);

    // Capture only: q must not move.
    tick(1'b0, 1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b0, 1'b1, 8'h01);
    chk("capture_q_idle", {24'd0, bus.q}, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 1'b1, 8'h01);
    chk("hold_q_idle", {24'd0, bus.q}, 32'h0);

    // Write-out, then hold with d changing underneath.
    tick(1'b0, 1'b1, 1'b0, 8'h01);
    chk("writeout", {24'd0, bus.q}, 32'h1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 8'h00);
    chk("writeout_hold", {24'd0, bus.q}, 32'h1);

    // Simultaneous enables: old store reaches q, new d reaches store.
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("simul_old", {24'd0, bus.q}, 32'h1);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    chk("simul_new", {24'd0, bus.q}, 32'h0);

    // Reset mid-operation discards the pending capture and write.
    tick(1'b0, 1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 1'b0, 8'h01);
    chk("pre_rst_q", {24'd0, bus.q}, 32'h1);
    tick(1'b1, 1'b0, 1'b0, 8'h01);
    chk("midrst_q", {24'd0, bus.q}, 32'h0);
`ifdef DFF_VALID_EN
    chk("midrst_valid", {31'd0, bus.valid}, 32'h0);
`endif
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    chk("midrst_store", {24'd0, bus.q}, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 8'h00);
`ifdef DFF_VALID_EN
    chk("valid_set", {31'd0, bus.valid}, 32'h1);
`endif

    // Continuous enables: two-edge pipeline.
    tick(1'b0, 1'b0, 1'b0, 8'h11);
    tick(1'b0, 1'b0, 1'b0, 8'h22);
    chk("pipe_11", {24'd0, bus.q}, 32'h11);
    tick(1'b0, 1'b0, 1'b0, 8'h33);
    chk("pipe_22", {24'd0, bus.q}, 32'h22);
    tick(1'b0, 1'b0, 1'b0, 8'h44);
    chk("pipe_33", {24'd0, bus.q}, 32'h33);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule : tb_dff

`default_nettype wire
